// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stall_en encodings, the ERET cause code and the
// hazard controller state enum.
package pipe_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [3:0] EXC_ERET = 4'hE;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // The deepest requesting stage wins, so only the four legal encodings can come out.
    function automatic logic [5:0] stall_encode(input logic id, input logic ex, input logic mem);
        logic [5:0] enc;
        if (mem) begin
            enc = STALL_MEM;
        end else if (ex) begin
            enc = STALL_EX;
        end else if (id) begin
            enc = STALL_ID;
        end else begin
            enc = STALL_NONE;
        end
        return enc;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles plus a sticky timeout flag
// that is cleared only by reset.
module stall_watchdog #(
    parameter int STALL_TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_i,
    output logic timeout_o
);

    localparam int RUN_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT - 1);

    logic [RUN_W-1:0] run_d;
    logic [RUN_W-1:0] run_q;
    logic             timeout_d;
    logic             timeout_q;

    // Next-state for the run counter and the sticky flag.
    always_comb begin
        run_d     = run_q;
        timeout_d = timeout_q;
        if (!stall_i) begin
            run_d = {RUN_W{1'b0}};
        end else if (run_q == RUN_MAX) begin
            run_d     = run_q;
            timeout_d = 1'b1;
        end else begin
            run_d = run_q + RUN_W'(1);
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q     <= {RUN_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline hazard controller: stall_en vector, flush/redirect, stall watchdog.
// Optional stall-cycle performance counter enabled by defining PIPE_PERF_CNT_EN.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int          STALL_TIMEOUT = 256,
    parameter int          CNT_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_req_id,
    input  logic              stall_req_ex,
    input  logic              stall_req_mem,
    input  logic              exc_valid,
    input  logic [3:0]        exc_type,
    input  logic [31:0]       epc,
    output logic [5:0]        stall_en,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              stall_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);

    state_e state_d;
    state_e state_q;
    logic   req_mask_s;
    logic   stalling_s;

    // ID/EX requests seen in the FLUSH cycle belong to killed instructions.
    always_comb begin
        req_mask_s = 1'b0;
        case (state_q)
            FLUSH:   req_mask_s = 1'b1;
            default: req_mask_s = 1'b0;
        endcase
    end

    // Same-cycle outputs and next state; RUN, STALL and FLUSH share one transition rule
    // once the FLUSH-cycle masking has been applied to the requests.
    always_comb begin
        stall_en = STALL_NONE;
        flush    = 1'b0;
        new_pc   = 32'h0000_0000;
        state_d  = state_q;
        if (reset) begin
            state_d = RUN;
        end else if (exc_valid) begin
            flush   = 1'b1;
            new_pc  = (exc_type == EXC_ERET) ? epc : EXC_VECTOR;
            state_d = FLUSH;
        end else begin
            stall_en = stall_encode(stall_req_id && !req_mask_s,
                                    stall_req_ex && !req_mask_s,
                                    stall_req_mem);
            state_d  = (stall_en != STALL_NONE) ? STALL : RUN;
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign stalling_s = (stall_en != STALL_NONE);

    stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .stall_i   (stalling_s),
        .timeout_o (stall_timeout)
    );

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cycles_d;
    logic [CNT_W-1:0] cycles_q;

    // Saturating stall-cycle counter.
    always_comb begin
        cycles_d = cycles_q;
        if (stalling_s && (cycles_q != {CNT_W{1'b1}})) begin
            cycles_d = cycles_q + CNT_W'(1);
        end else begin
            cycles_d = cycles_q;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= {CNT_W{1'b0}};
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign stall_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (STALL_TIMEOUT=4) with a queue scoreboard.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_req_id;
    logic        stall_req_ex;
    logic        stall_req_mem;
    logic        exc_valid;
    logic [3:0]  exc_type;
    logic [31:0] epc;
    logic [5:0]  stall_en;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] exp_cyc = 32'd0;
`endif

    typedef struct {
        logic [5:0]  se;
        logic        fl;
        logic [31:0] pc;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .EXC_VECTOR    (32'h0000_0020),
        .STALL_TIMEOUT (4),
        .CNT_W         (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_req_id  (stall_req_id),
        .stall_req_ex  (stall_req_ex),
        .stall_req_mem (stall_req_mem),
        .exc_valid     (exc_valid),
        .exc_type      (exc_type),
        .epc           (epc),
        .stall_en      (stall_en),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
            $error("%s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then check the scoreboard entry.
    task automatic step(input string tag,
                        input logic rst, input logic id, input logic ex, input logic mem,
                        input logic exc, input logic [3:0] et, input logic [31:0] ep,
                        input logic [5:0] se, input logic fl, input logic [31:0] pc,
                        input logic to);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        stall_req_id  = id;
        stall_req_ex  = ex;
        stall_req_mem = mem;
        exc_valid     = exc;
        exc_type      = et;
        epc           = ep;
        e.se = se;
        e.fl = fl;
        e.pc = pc;
        e.to = to;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        chk({tag, "/stall_en"}, {26'd0, stall_en}, {26'd0, e.se});
        chk({tag, "/flush"}, {31'd0, flush}, {31'd0, e.fl});
        chk({tag, "/new_pc"}, new_pc, e.pc);
        chk({tag, "/timeout"}, {31'd0, stall_timeout}, {31'd0, e.to});
`ifdef PIPE_PERF_CNT_EN
        chk({tag, "/cycles"}, stall_cycles, exp_cyc);
        if (rst) begin
            exp_cyc = 32'd0;
        end else if (se != 6'd0 && exp_cyc != 32'hFFFF_FFFF) begin
            exp_cyc = exp_cyc + 32'd1;
        end
`endif
    endtask

    initial begin
        reset = 1'b1; stall_req_id = 1'b0; stall_req_ex = 1'b0; stall_req_mem = 1'b0;
        exc_valid = 1'b0; exc_type = 4'h0; epc = 32'h0;

        // reset: inputs ignored
        step("rst0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hE, 32'h1234, 6'h00, 1'b0, 32'h0, 1'b0);
        step("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        // ID load-use stall for 3 cycles
        step("id1",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h07, 1'b0, 32'h0, 1'b0);
        step("id2",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h07, 1'b0, 32'h0, 1'b0);
        step("id3",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h07, 1'b0, 32'h0, 1'b0);
        step("idA",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        // priority between requests
        step("idex", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b0);
        step("all3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0,    6'h1F, 1'b0, 32'h0, 1'b0);
        step("idB",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        // exception beats MEM stall, then EX request masked in FLUSH cycle
        step("exc8", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 32'h0,    6'h00, 1'b1, 32'h20, 1'b0);
        step("mskx", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        step("unmx", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b0);
        step("idC",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        // MEM request honoured during FLUSH
        step("exc3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 32'h0,    6'h00, 1'b1, 32'h20, 1'b0);
        step("flmm", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,    6'h1F, 1'b0, 32'h0, 1'b0);
        step("idD",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        // ERET redirects to epc for one cycle
        step("eret", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 32'h1234, 6'h00, 1'b1, 32'h1234, 1'b0);
        step("post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 32'h1234, 6'h00, 1'b0, 32'h0, 1'b0);
        // watchdog: flag visible after the 4th stalled cycle, sticky after release
        step("wd1",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b0);
        step("wd2",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b0);
        step("wd3",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b0);
        step("wd4",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b0);
        step("wd5",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b1);
        step("wd6",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b1);
        step("wd7",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b1);
        // reset during a stall clears flag and stall_en
        step("wdrs", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b1);
        step("wdcl", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        // seven stalled cycles separated by idle gaps
        step("p1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h07, 1'b0, 32'h0, 1'b0);
        step("g1",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        step("p2",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b0);
        step("p3",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b0);
        step("g2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        step("p4",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,    6'h1F, 1'b0, 32'h0, 1'b0);
        step("g3",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        step("p5",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h07, 1'b0, 32'h0, 1'b0);
        step("p6",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h07, 1'b0, 32'h0, 1'b0);
        step("g4",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        step("p7",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    6'h0F, 1'b0, 32'h0, 1'b0);
        step("g5",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("cyc7", stall_cycles, 32'd7);
`endif
        // reset in the middle of a stall
        step("ms1",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h07, 1'b0, 32'h0, 1'b0);
        step("msrs", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
        step("ms2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    6'h00, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("cyc0", stall_cycles, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
